// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed 4-digit seven-segment bus: synchronise, debounce each digit,
// decode it back to a hex nibble and report a 16-bit frame once all four digits have been seen.
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit EN_ACTIVE_LOW  = 1'b0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  digit_en_in,
  output logic [15:0] value_o,
  output logic [3:0]  dp_o,
  output logic        frame_vld_o,
  output logic        frame_err_o,
  output logic        timeout_o
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_TOP = TW'(TIMEOUT_CYCLES);

  typedef enum logic {EMPTY, FILLING} state_t;

  logic [7:0]    seg_s1_q, seg_s2_q;
  logic [3:0]    en_s1_q, en_s2_q;
  logic [11:0]   prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  state_t        state_q, state_d;
  logic [3:0]    mask_q, mask_d, bad_q, bad_d, dpb_q, dpb_d;
  logic [15:0]   nib_q, nib_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [15:0]   value_q, value_d;
  logic [3:0]    dp_q, dp_d;
  logic          vld_q, vld_d, err_q, err_d, tmo_q, tmo_d;

  logic [7:0]  seg_n;
  logic [3:0]  en_n;
  logic [11:0] sample;
  logic        one_hot, same, capture;
  logic [1:0]  idx;
  logic [4:0]  dec;

  // {bad, nibble}; unknown patterns decode to nibble 0 with the bad bit set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h00;  7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;  7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;  7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;  7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;  7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;  7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;  7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;  7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    seg_n   = seg_s2_q ^ {8{SEG_ACTIVE_LOW}};
    en_n    = en_s2_q ^ {4{EN_ACTIVE_LOW}};
    sample  = {en_n, seg_n};
    one_hot = (en_n != 4'b0000) && ((en_n & (en_n - 4'd1)) == 4'b0000);
    same    = one_hot && (sample == prev_q);
    cnt_d   = '0;
    if (same) cnt_d = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
    // The done flag survives only while the sample is unchanged, so a held digit captures once.
    capture = one_hot && (cnt_d == CNT_TOP) && !(same && done_q);
    done_d  = capture || (same && done_q);
    dec     = decode(seg_n[6:0]);
    case (en_n)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // frame_vld_o and timeout_o are single-cycle strobes with no ready/backpressure; a consumer
  // must take value_o/dp_o/frame_err_o in the cycle frame_vld_o is high.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    bad_d   = bad_q;
    nib_d   = nib_q;
    dpb_d   = dpb_q;
    idle_d  = idle_q;
    value_d = value_q;
    dp_d    = dp_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    tmo_d   = 1'b0;
    if (capture) begin
      mask_d[idx]             = 1'b1;
      bad_d[idx]              = dec[4];
      nib_d[{idx, 2'b00} +: 4] = dec[3:0];
      dpb_d[idx]              = seg_n[7];
      idle_d                  = '0;
      state_d                 = FILLING;
      if (mask_d == 4'hF) begin
        value_d = nib_d;
        dp_d    = dpb_d;
        err_d   = |bad_d;
        vld_d   = 1'b1;
        mask_d  = 4'h0;
        bad_d   = 4'h0;
        state_d = EMPTY;
      end
    end else if (state_q == FILLING) begin
      if (idle_q + 1'b1 == IDLE_TOP) begin
        mask_d  = 4'h0;
        bad_d   = 4'h0;
        idle_d  = '0;
        tmo_d   = 1'b1;
        state_d = EMPTY;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      en_s1_q  <= '0;
      en_s2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      state_q  <= EMPTY;
      mask_q   <= '0;
      bad_q    <= '0;
      nib_q    <= '0;
      dpb_q    <= '0;
      idle_q   <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      en_s1_q  <= digit_en_in;
      en_s2_q  <= en_s1_q;
      prev_q   <= sample;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      state_q  <= state_d;
      mask_q   <= mask_d;
      bad_q    <= bad_d;
      nib_q    <= nib_d;
      dpb_q    <= dpb_d;
      idle_q   <= idle_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign value_o     = value_q;
  assign dp_o        = dp_q;
  assign frame_vld_o = vld_q;
  assign frame_err_o = err_q;
  assign timeout_o   = tmo_q;

endmodule
